// File: rtl/hack_data_memory_pkg.sv
// rtl/hack_data_memory_pkg.sv - Hack data-memory map constants, region type and address decode.
package hack_mem_pkg;

  localparam int WORD_W       = 16;
  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_WORDS = 8192;

  localparam logic [WORD_W-1:0] SCREEN_BASE = 16'd16384;
  localparam logic [WORD_W-1:0] KBD_ADDR    = 16'd24576;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_SCREEN,
    REG_KBD,
    REG_NONE
  } region_e;

  // Bit 15 set is always outside the map, whatever the low bits say.
  function automatic region_e decode_region(input logic [WORD_W-1:0] addr);
    if (addr[15])               return REG_NONE;
    else if (addr < SCREEN_BASE) return REG_RAM;
    else if (addr < KBD_ADDR)    return REG_SCREEN;
    else if (addr == KBD_ADDR)   return REG_KBD;
    else                         return REG_NONE;
  endfunction

endpackage

// File: rtl/hack_data_memory_if.sv
// rtl/hack_data_memory_if.sv - CPU bus, display port and keyboard handshake bundle.
interface hack_data_memory_if #(
  parameter int CNT_W = 3
);

  logic [15:0]      addressM;
  logic [15:0]      outM;
  logic             loadM;
  logic [15:0]      inM;

  logic [12:0]      scr_addr;
  logic [15:0]      scr_data;

  logic             key_valid;
  logic [15:0]      key_data;
  logic             key_ready;
  logic [CNT_W-1:0] kbd_count;

  modport master (
    output addressM, outM, loadM, scr_addr, key_valid, key_data,
    input  inM, scr_data, key_ready, kbd_count
  );

  modport slave (
    input  addressM, outM, loadM, scr_addr, key_valid, key_data,
    output inM, scr_data, key_ready, kbd_count
  );

endinterface

// File: rtl/hack_data_memory_kbd_fifo.sv
// rtl/hack_data_memory_kbd_fifo.sv - Keyboard scan-code FIFO with occupancy count and wrapping pointers.
module hack_kbd_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/hack_data_memory.sv
// rtl/hack_data_memory.sv - Hack data memory: RAM, screen with display read port, buffered keyboard.
module hack_data_memory
  import hack_mem_pkg::*;
#(
  parameter int KBD_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  hack_data_memory_if.slave    bus
);

  logic [WORD_W-1:0] ram_q [RAM_WORDS];
  logic [WORD_W-1:0] scr_q [SCREEN_WORDS];
  logic [WORD_W-1:0] scr_data_q, scr_data_d;

  region_e           region;
  logic [13:0]       ram_idx;
  logic [12:0]       scr_idx;

  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              key_ready;

  assign region  = decode_region(bus.addressM);
  assign ram_idx = bus.addressM[13:0];
  // Screen spans 16384..24575, so the low 13 bits are already the word index.
  assign scr_idx = bus.addressM[12:0];

  always_comb begin
    bus.inM = '0;
    case (region)
      REG_RAM:    bus.inM = ram_q[ram_idx];
      REG_SCREEN: bus.inM = scr_q[scr_idx];
      REG_KBD:    bus.inM = fifo_empty ? '0 : fifo_head;
      default:    bus.inM = '0;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.loadM && region == REG_RAM)    ram_q[ram_idx] <= bus.outM;
    if (bus.loadM && region == REG_SCREEN) scr_q[scr_idx] <= bus.outM;
  end

  assign scr_data_d = scr_q[bus.scr_addr];

  always_ff @(posedge clk) begin
    if (reset) scr_data_q <= '0;
    else       scr_data_q <= scr_data_d;
  end

  assign bus.scr_data = scr_data_q;

  // A zero scan code completes the handshake but is never queued.
  assign key_ready = !fifo_full && !reset;
  assign fifo_push = bus.key_valid && key_ready && (bus.key_data != '0);
  assign fifo_pop  = bus.loadM && (region == REG_KBD);

  hack_kbd_fifo #(
    .DEPTH (KBD_DEPTH),
    .CNT_W (CNT_W),
    .W     (WORD_W)
  ) u_kbd_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.key_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.key_ready = key_ready;
  assign bus.kbd_count = fifo_count;

endmodule

// File: tb/tb_hack_data_memory.sv
// tb/tb_hack_data_memory.sv - Directed and randomized checks of hack_data_memory against a queue/array model.
module tb_hack_data_memory;

  localparam int KBD_DEPTH = 4;
  localparam int CNT_W     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hack_data_memory_if #(.CNT_W(CNT_W)) bus ();

  hack_data_memory #(
    .KBD_DEPTH (KBD_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  logic [15:0] mem_m [24576];
  bit          wr_m  [24576];
  logic [15:0] fifo_m [$];
  logic [15:0] scr_exp;
  bit          scr_known;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic ld);
    bus.addressM = a;
    bus.outM     = d;
    bus.loadM    = ld;
    #1;
  endtask

  task automatic model_inM(input logic [15:0] a, output bit known, output logic [15:0] v);
    known = 1'b1;
    v     = 16'd0;
    if (a < 16'd24576) begin
      known = wr_m[a];
      v     = mem_m[a];
    end else if (a == 16'd24576) begin
      v = (fifo_m.size() > 0) ? fifo_m[0] : 16'd0;
    end
  endtask

  // Model one clock edge from the inputs currently applied, then step past the edge.
  task automatic tick();
    bit          rdy;
    int          si;
    rdy = !rst && (fifo_m.size() < KBD_DEPTH);
    si  = 16384 + int'(bus.scr_addr);
    if (rst) begin
      scr_known = 1'b1;
      scr_exp   = 16'd0;
      fifo_m.delete();
    end else begin
      scr_known = wr_m[si];
      scr_exp   = mem_m[si];
      if (bus.loadM && bus.addressM == 16'd24576 && fifo_m.size() > 0) void'(fifo_m.pop_front());
      if (bus.key_valid && rdy && bus.key_data != 16'd0) fifo_m.push_back(bus.key_data);
    end
    if (bus.loadM && bus.addressM < 16'd24576) begin
      mem_m[bus.addressM] = bus.outM;
      wr_m[bus.addressM]  = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_comb(input string tag);
    bit          k;
    logic [15:0] v;
    model_inM(bus.addressM, k, v);
    if (k) chk({tag, ".inM"}, bus.inM, v);
    chk({tag, ".key_ready"}, 16'(bus.key_ready), 16'(!rst && fifo_m.size() < KBD_DEPTH));
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, ".kbd_count"}, 16'(bus.kbd_count), 16'(fifo_m.size()));
    if (scr_known) chk({tag, ".scr_data"}, bus.scr_data, scr_exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.addressM = '0; bus.outM = '0; bus.loadM = 1'b0;
    bus.scr_addr = '0; bus.key_valid = 1'b0; bus.key_data = '0;
    tick(); tick();
    chk("rst.count", 16'(bus.kbd_count), 16'd0);
    chk("rst.ready", 16'(bus.key_ready), 16'd0);
    chk("rst.scr", bus.scr_data, 16'd0);
    rst = 1'b0; #1;
    chk("post_rst.ready", 16'(bus.key_ready), 16'd1);

    drive(16'd1000, 16'd11111, 1'b1); tick();
    drive(16'd1000, 16'd0, 1'b0); chk("ram1000", bus.inM, 16'd11111);
    drive(16'd1001, 16'd11110, 1'b1); tick();
    drive(16'd1001, 16'd0, 1'b0); chk("ram1001", bus.inM, 16'd11110);
    drive(16'd1000, 16'd222, 1'b1); chk("rdw.old", bus.inM, 16'd11111); tick();
    drive(16'd1000, 16'd0, 1'b0); chk("rdw.new", bus.inM, 16'd222);

    drive(16'd16389, 16'hA5A5, 1'b1); tick();
    drive(16'd16389, 16'd0, 1'b0); chk("scr.cpu_read", bus.inM, 16'hA5A5);
    bus.scr_addr = 13'd5; tick();
    chk("scr.disp", bus.scr_data, 16'hA5A5);
    drive(16'd16389, 16'h5A5A, 1'b1); tick();
    chk("scr.same_cycle_old", bus.scr_data, 16'hA5A5);
    drive(16'd0, 16'd0, 1'b0); tick();
    chk("scr.new", bus.scr_data, 16'h5A5A);

    bus.key_valid = 1'b1; bus.key_data = 16'd65; tick();
    bus.key_data = 16'd66; tick();
    bus.key_valid = 1'b0;
    drive(16'd24576, 16'd0, 1'b0);
    chk("kbd.head65", bus.inM, 16'd65);
    chk("kbd.count2", 16'(bus.kbd_count), 16'd2);
    drive(16'd24576, 16'd0, 1'b1); tick();
    drive(16'd24576, 16'd0, 1'b0);
    chk("kbd.head66", bus.inM, 16'd66);
    chk("kbd.count1", 16'(bus.kbd_count), 16'd1);
    drive(16'd24576, 16'd0, 1'b1); tick();
    drive(16'd24576, 16'd0, 1'b0);
    chk("kbd.empty_read", bus.inM, 16'd0);
    drive(16'd24576, 16'd0, 1'b1); tick();
    chk("kbd.pop_empty", 16'(bus.kbd_count), 16'd0);
    bus.key_valid = 1'b1; bus.key_data = 16'd77; tick();
    chk("kbd.pushpop_empty", 16'(bus.kbd_count), 16'd1);
    bus.key_data = 16'd78; tick();
    chk("kbd.pushpop_nonempty", 16'(bus.kbd_count), 16'd1);
    bus.key_valid = 1'b0;
    drive(16'd24576, 16'd0, 1'b0);
    chk("kbd.head78", bus.inM, 16'd78);
    drive(16'd24576, 16'd0, 1'b1); tick();

    drive(16'd0, 16'd0, 1'b0);
    bus.key_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      bus.key_data = 16'(k); tick();
    end
    chk("full.ready", 16'(bus.key_ready), 16'd0);
    chk("full.count", 16'(bus.kbd_count), 16'd4);
    bus.key_data = 16'd5; tick();
    chk("full.refused", 16'(bus.kbd_count), 16'd4);
    drive(16'd24576, 16'd0, 1'b1); tick();
    chk("full.pushpop", 16'(bus.kbd_count), 16'd3);
    drive(16'd24576, 16'd0, 1'b0); tick();
    chk("full.refill", 16'(bus.kbd_count), 16'd4);
    bus.key_valid = 1'b0;
    for (int e = 2; e <= 5; e++) begin
      drive(16'd24576, 16'd0, 1'b0);
      chk("drain.order", bus.inM, 16'(e));
      drive(16'd24576, 16'd0, 1'b1); tick();
    end
    chk("drain.count", 16'(bus.kbd_count), 16'd0);

    drive(16'd0, 16'd0, 1'b0);
    bus.key_valid = 1'b1; bus.key_data = 16'd0; #1;
    chk("zero_key.ready", 16'(bus.key_ready), 16'd1);
    tick();
    chk("zero_key.count", 16'(bus.kbd_count), 16'd0);
    bus.key_valid = 1'b0;
    drive(16'd30000, 16'd1234, 1'b1); tick();
    drive(16'd30000, 16'd0, 1'b0); chk("unmapped30000", bus.inM, 16'd0);
    drive(16'd40000, 16'd4321, 1'b1); tick();
    drive(16'd40000, 16'd0, 1'b0); chk("unmapped40000", bus.inM, 16'd0);
    drive(16'd16383, 16'd7, 1'b1); tick();
    drive(16'd16383, 16'd0, 1'b0); chk("ram_top", bus.inM, 16'd7);

    bus.key_valid = 1'b1;
    for (int k = 11; k <= 13; k++) begin
      bus.key_data = 16'(k); tick();
    end
    bus.key_valid = 1'b0;
    drive(16'd0, 16'd9, 1'b1); tick();
    chk("pre_rst.count", 16'(bus.kbd_count), 16'd3);
    rst = 1'b1;
    bus.key_valid = 1'b1; bus.key_data = 16'd20;
    drive(16'd24576, 16'd0, 1'b1);
    chk("rst_mid.ready", 16'(bus.key_ready), 16'd0);
    tick();
    chk("rst_mid.count", 16'(bus.kbd_count), 16'd0);
    chk("rst_mid.scr", bus.scr_data, 16'd0);
    rst = 1'b0; bus.key_valid = 1'b0;
    drive(16'd0, 16'd0, 1'b0);
    chk("rst_mid.ram0", bus.inM, 16'd9);
    drive(16'd24576, 16'd0, 1'b0);
    chk("rst_mid.kbd", bus.inM, 16'd0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      case ($urandom_range(0, 6))
        0: a = 16'($urandom_range(0, 15));
        1: a = 16'($urandom_range(16384, 16391));
        2: a = 16'd24576;
        3: a = 16'd24576;
        4: a = 16'd30000;
        5: a = 16'd40000;
        default: a = 16'd16383;
      endcase
      bus.key_valid = 1'($urandom_range(0, 1));
      bus.key_data  = 16'($urandom_range(0, 3));
      bus.scr_addr  = 13'($urandom_range(0, 7));
      rst           = ($urandom_range(0, 49) == 0);
      drive(a, 16'($urandom), 1'($urandom_range(0, 1)));
      chk_comb("rnd");
      tick();
      chk_seq("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
